// File: rtl/seqdiv_pkg.sv
// Shared constants and types for the 128/64 restoring divider.
package seqdiv_pkg;

  localparam int unsigned WIDTH_C    = 64;
  localparam int unsigned STEP_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage : seqdiv_pkg

// File: rtl/divstep_64.sv
// One radix-2 restoring division step: shift in a dividend bit, subtract if it fits.
module divstep_64
  import seqdiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_C
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_o,
  output logic             qbit
);

  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] diff;

  // Trial is kept one bit wider than the remainder so no carry is ever lost.
  always_comb begin
    trial = {rem_i, shift_in};
    diff  = trial - {2'b00, divisor};
    qbit  = (trial >= {2'b00, divisor});
    rem_o = qbit ? (WIDTH+1)'(diff) : (WIDTH+1)'(trial);
  end

endmodule : divstep_64

// File: rtl/seqdiv_64.sv
// Iterative 128/64 unsigned divider, one quotient bit per clock, start/done handshake.
module seqdiv_64
  import seqdiv_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_C
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  div_state_t            state_q, state_d;
  logic [WIDTH:0]        rem_q, rem_d;
  logic [WIDTH-1:0]      q_q, q_d;
  logic [WIDTH-1:0]      dvsr_q, dvsr_d;
  logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [WIDTH-1:0]      quot_q, quot_d;
  logic [WIDTH-1:0]      remd_q, remd_d;
  logic                  dbz_q, dbz_d;
  logic                  ovf_q, ovf_d;

  logic [WIDTH:0]        step_rem;
  logic                  step_qbit;
  logic [WIDTH-1:0]      q_next;

  divstep_64 #(.WIDTH(WIDTH)) u_step (
    .rem_i    (rem_q),
    .shift_in (q_q[WIDTH-1]),
    .divisor  (dvsr_q),
    .rem_o    (step_rem),
    .qbit     (step_qbit)
  );

  assign q_next = {q_q[WIDTH-2:0], step_qbit};

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    remd_d  = remd_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          dbz_d  = 1'b0;
          ovf_d  = 1'b0;
          dvsr_d = divisor;
          cnt_d  = '0;
          if (divisor == '0) begin
            dbz_d   = 1'b1;
            quot_d  = '1;
            remd_d  = dividend[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = DONE;
          end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
            // Quotient would need more than WIDTH bits.
            ovf_d   = 1'b1;
            quot_d  = '1;
            remd_d  = dividend[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = {1'b0, dividend[2*WIDTH-1:WIDTH]};
            q_d     = dividend[WIDTH-1:0];
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        q_d   = q_next;
        cnt_d = STEP_CNT_W'(cnt_q + 1'b1);
        if (cnt_q == STEP_CNT_W'(WIDTH - 1)) begin
          quot_d  = q_next;
          remd_d  = step_rem[WIDTH-1:0];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remd_q  <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remd_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule : seqdiv_64

// File: tb/tb_seqdiv_64.sv
// Directed self-checking bench for seqdiv_64 and its divstep_64 step.
module tb_seqdiv_64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] dividend;
  logic [63:0]  divisor;
  logic         busy, done, div_by_zero, overflow;
  logic [63:0]  quotient, remainder;

  logic [64:0]  st_rem_i, st_rem_o;
  logic         st_shift, st_qbit;
  logic [63:0]  st_dvs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seqdiv_64 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  divstep_64 ref_step (
    .rem_i    (st_rem_i),
    .shift_in (st_shift),
    .divisor  (st_dvs),
    .rem_o    (st_rem_o),
    .qbit     (st_qbit)
  );

  typedef struct {
    logic [127:0] dvd;
    logic [63:0]  dvs;
    logic [63:0]  q;
    logic [63:0]  r;
    logic         dbz;
    logic         ovf;
    int           lat;
    int           busy_cyc;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Launch one operation and wait (bounded) for its done pulse.
  task automatic run_op(input logic [127:0] dvd, input logic [63:0] dvs,
                        output logic [63:0] q, output logic [63:0] r,
                        output logic dbz, output logic ovf,
                        output int lat, output int busy_cyc, output logic done_after);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cyc++;
      @(posedge clk);
      #1 lat++;
    end
    q   = quotient;
    r   = remainder;
    dbz = div_by_zero;
    ovf = overflow;
    while (busy && busy_cyc < 300) begin
      busy_cyc++;
      @(posedge clk);
      #1;
    end
    done_after = done;
  endtask

  initial begin
    logic [63:0] q, r;
    logic        dbz, ovf, dafter, seen;
    int          lat, bc;
    logic [63:0] a, b;

    a = 64'hF0F0_F0F0_F0F0_F0F0;
    b = 64'h0F0F_0F0F_0F0F_0F0F;
    vecs[0] = '{128'(a) * 128'(b), b, a, 64'h0, 1'b0, 1'b0, 64, 65};
    vecs[1] = '{128'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0, 64, 65};
    vecs[2] = '{128'h1234, 64'd0, '1, 64'h1234, 1'b1, 1'b0, 0, 1};
    vecs[3] = '{{64'h5, 64'h0}, 64'd5, '1, 64'h0, 1'b0, 1'b1, 0, 1};
    vecs[4] = '{{64'h4, 64'h0}, 64'd5, 64'hCCCC_CCCC_CCCC_CCCC, 64'd4, 1'b0, 1'b0, 64, 65};
    vecs[5] = '{{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF}, '1, '1,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 64, 65};
    vecs[6] = '{128'd0, 64'd1, 64'd0, 64'd0, 1'b0, 1'b0, 64, 65};
    vecs[7] = '{{64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 64'd1, '1, 64'd0, 1'b0, 1'b0, 64, 65};
    vecs[8] = '{{64'hFFFF_FFFF_FFFF_FFFF, 64'h77}, '1, '1, 64'h77, 1'b0, 1'b1, 0, 1};

    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset done", 128'(done), 128'(0));
    chk("reset quotient", 128'(quotient), 128'(0));
    chk("reset remainder", 128'(remainder), 128'(0));
    chk("reset flags", 128'({div_by_zero, overflow}), 128'(0));

    // Single-step reference checks on the combinational step.
    st_rem_i = 65'd3; st_shift = 1'b1; st_dvs = 64'd7;
    #1 chk("step 7/7", 128'({st_qbit, st_rem_o}), 128'({1'b1, 65'd0}));
    st_rem_i = 65'd2; st_shift = 1'b0; st_dvs = 64'd7;
    #1 chk("step 4/7", 128'({st_qbit, st_rem_o}), 128'({1'b0, 65'd4}));
    st_rem_i = 65'h0_8000_0000_0000_0000; st_shift = 1'b0; st_dvs = '1;
    #1 chk("step carry", 128'({st_qbit, st_rem_o}), 128'({1'b1, 65'd1}));

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].dvd, vecs[i].dvs, q, r, dbz, ovf, lat, bc, dafter);
      chk($sformatf("v%0d quotient", i), 128'(q), 128'(vecs[i].q));
      chk($sformatf("v%0d remainder", i), 128'(r), 128'(vecs[i].r));
      chk($sformatf("v%0d div_by_zero", i), 128'(dbz), 128'(vecs[i].dbz));
      chk($sformatf("v%0d overflow", i), 128'(ovf), 128'(vecs[i].ovf));
      chk($sformatf("v%0d latency", i), 128'(lat), 128'(vecs[i].lat));
      chk($sformatf("v%0d busy cycles", i), 128'(bc), 128'(vecs[i].busy_cyc));
      chk($sformatf("v%0d done pulse", i), 128'(dafter), 128'(0));
    end

    // Start pulse and operand change in mid-RUN must be ignored.
    @(negedge clk);
    dividend = 128'd100;
    divisor  = 64'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      if (lat == 20) begin
        start = 1'b1;
        dividend = 128'd1000;
        divisor = 64'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1 lat++;
    end
    start = 1'b0;
    chk("ignored start latency", 128'(lat), 128'(64));
    chk("ignored start quotient", 128'(quotient), 128'(14));
    chk("ignored start remainder", 128'(remainder), 128'(2));

    // Results hold through idle cycles.
    repeat (5) @(negedge clk);
    chk("hold busy", 128'(busy), 128'(0));
    chk("hold quotient", 128'(quotient), 128'(14));
    chk("hold remainder", 128'(remainder), 128'(2));

    // Reset in the middle of RUN.
    @(negedge clk);
    dividend = 128'd100;
    divisor  = 64'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset busy", 128'(busy), 128'(0));
    chk("mid reset quotient", 128'(quotient), 128'(0));
    chk("mid reset remainder", 128'(remainder), 128'(0));
    chk("mid reset done/flags", 128'({done, div_by_zero, overflow}), 128'(0));
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (70) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("no done after abort", 128'(seen), 128'(0));

    run_op(128'd100, 64'd7, q, r, dbz, ovf, lat, bc, dafter);
    chk("post reset quotient", 128'(q), 128'(14));
    chk("post reset remainder", 128'(r), 128'(2));
    chk("post reset flags", 128'({dbz, ovf}), 128'(0));
    chk("post reset latency", 128'(lat), 128'(64));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_seqdiv_64
